// File: rtl/bnn_result_collector_pkg.sv
// rtl/bnn_result_collector_pkg.sv - shared constants and types for the BNN result collector
// Purpose: widths of the core result half and packed output word, instruction bit
//          positions used by the controller, and the pair FSM state type.
// Ports:   none (package).
package bnn_result_collector_pkg;

  localparam int BIN_W           = 32;
  localparam int WORD_W          = 64;
  localparam int INSTR_STORE_BIT = 14;
  localparam int INSTR_HALF_BIT  = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    LO_HELD = 1'b1
  } pair_state_t;

endpackage

// File: rtl/bnn_result_collector_if.sv
// rtl/bnn_result_collector_if.sv - core/writer/controller signal bundle for the result collector
// Purpose: groups the core store inputs, layer configuration, output stream and status.
// Ports (slave = collector view):
//   in : store, half_sel, result_bins[31:0], layer_start, cfg_words[CNT_W-1:0], out_ready
//   out: out_data[63:0], out_valid, out_last, stall, err_seq, err_ovf
interface bnn_result_collector_if #(
  parameter int CNT_W = 16
) ();
  import bnn_result_collector_pkg::*;

  logic              store;
  logic              half_sel;
  logic [BIN_W-1:0]  result_bins;
  logic              layer_start;
  logic [CNT_W-1:0]  cfg_words;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              stall;
  logic              err_seq;
  logic              err_ovf;

  modport master (
    output store, half_sel, result_bins, layer_start, cfg_words, out_ready,
    input  out_data, out_valid, out_last, stall, err_seq, err_ovf
  );

  modport slave (
    input  store, half_sel, result_bins, layer_start, cfg_words, out_ready,
    output out_data, out_valid, out_last, stall, err_seq, err_ovf
  );

endinterface

// File: rtl/bnn_result_collector_fifo.sv
// rtl/bnn_result_collector_fifo.sv - synchronous FIFO holding packed words plus last tag
// Purpose: DEPTH-entry single-clock FIFO. The caller only asserts push_i when the
//          write is allowed (not full, or a pop happens on the same edge).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, data_i    write strobe and data
//   pop_i             read strobe (ignored while empty)
//   data_o            head entry, forced to 0 while empty
//   full_o, empty_o   occupancy flags
//   count_o           occupancy, clog2(DEPTH)+1 bits
module bnn_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  // Head is zeroed when empty so stale storage never shows on the outputs.
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    // Power-of-two depth: pointers wrap naturally.
    if (push_i) wr_d = wr_q + 1'b1;
    if (do_pop) rd_d = rd_q + 1'b1;
    if (push_i && !do_pop)      count_d = count_q + 1'b1;
    else if (!push_i && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/bnn_result_collector.sv
// rtl/bnn_result_collector.sv - pairs core result halves into 64-bit words and streams them out
// Purpose: latches the low half, packs {hi,lo} on the high half, tags the last word
//          of each layer, buffers words in a FIFO and reports stall and sticky errors.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        slave view of bnn_result_collector_if (store inputs, layer config,
//              out_data/out_valid/out_ready/out_last stream, stall, err_seq, err_ovf)
module bnn_result_collector
  import bnn_result_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  bnn_result_collector_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  pair_state_t      state_q, state_d;
  logic [BIN_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cfg_q, cfg_d;
  logic             err_seq_q, err_seq_d;
  logic             err_ovf_q, err_ovf_d;

  logic             push_req;
  logic             push_acc;
  logic             pop;
  logic             is_last;
  logic [CNT_W-1:0] idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WORD_W:0]  fifo_head;

  // Pair FSM. result_bins is only looked at inside the store branch so an
  // undriven bus between stores cannot leak into lo or the FIFO.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    err_seq_d = err_seq_q;
    push_req  = 1'b0;
    if (bus.store) begin
      case (state_q)
        IDLE: begin
          if (!bus.half_sel) begin
            lo_d    = bus.result_bins;
            state_d = LO_HELD;
          end else begin
            err_seq_d = 1'b1;
          end
        end
        LO_HELD: begin
          if (bus.half_sel) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            lo_d      = bus.result_bins;
            err_seq_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop      = ~fifo_empty & bus.out_ready;
  // A full FIFO still takes the word if the head leaves on the same edge.
  assign push_acc = push_req & (~fifo_full | pop);

  // layer_start on the same edge as a push makes that push index 0 of the new layer.
  always_comb begin
    idx       = bus.layer_start ? '0 : cnt_q;
    cfg_d     = bus.layer_start ? bus.cfg_words : cfg_q;
    // cfg 0 wraps to all-ones here, giving a 2^CNT_W word layer.
    is_last   = (idx == (cfg_d - CNT_W'(1)));
    cnt_d     = idx;
    if (push_acc) cnt_d = is_last ? '0 : idx + 1'b1;
    err_ovf_d = err_ovf_q | (push_req & ~push_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      cnt_q     <= '0;
      cfg_q     <= '0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      err_seq_q <= err_seq_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  bnn_sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_acc),
    .data_i  ({is_last, bus.result_bins, lo_q}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // All outputs come from registered state only.
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_head[WORD_W-1:0];
  assign bus.out_last  = fifo_head[WORD_W];
  assign bus.stall     = (fifo_count >= CW'(DEPTH - 1));
  assign bus.err_seq   = err_seq_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bnn_result_collector.sv
// tb/tb_bnn_result_collector.sv - self-checking bench for bnn_result_collector
module tb_bnn_result_collector;

  localparam int DEPTH = 8;

  typedef struct {
    logic [63:0] d;
    bit          last;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_result_collector_if #(.CNT_W(16)) bus ();

  bnn_result_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  ent_t        mq[$];
  bit          m_lo_pend;
  logic [31:0] m_lo;
  int          m_idx;
  int          m_cfg;
  bit          m_eseq;
  bit          m_eovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit   m_pop;
    bit   m_push;
    logic [63:0] w;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_lo_pend = 0;
      m_lo      = '0;
      m_idx     = 0;
      m_cfg     = 65536;
      m_eseq    = 0;
      m_eovf    = 0;
    end else begin
      m_pop  = (mq.size() != 0) && (bus.out_ready === 1'b1);
      m_push = 0;
      w      = '0;
      if (bus.store) begin
        if (!bus.half_sel) begin
          if (m_lo_pend) m_eseq = 1;
          m_lo      = bus.result_bins;
          m_lo_pend = 1;
        end else if (!m_lo_pend) begin
          m_eseq = 1;
        end else begin
          m_push    = 1;
          w         = {bus.result_bins, m_lo};
          m_lo_pend = 0;
        end
      end
      if (bus.layer_start) begin
        m_idx = 0;
        m_cfg = (bus.cfg_words == 0) ? 65536 : int'(bus.cfg_words);
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) begin
          e.d    = w;
          e.last = (m_idx == m_cfg - 1);
          mq.push_back(e);
          m_idx  = e.last ? 0 : (m_idx + 1) % 65536;
        end else begin
          m_eovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("out_data",  bus.out_data, (mq.size() != 0) ? mq[0].d : 64'h0);
      chk("out_last",  64'(bus.out_last), (mq.size() != 0) ? 64'(mq[0].last) : 64'h0);
      chk("stall",     64'(bus.stall), 64'(mq.size() >= DEPTH - 1));
      chk("err_seq",   64'(bus.err_seq), 64'(m_eseq));
      chk("err_ovf",   64'(bus.err_ovf), 64'(m_eovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic store_word(input logic hs, input logic [31:0] v);
    bus.store       = 1'b1;
    bus.half_sel    = hs;
    bus.result_bins = v;
    tick();
    bus.store       = 1'b0;
    bus.half_sel    = 1'b0;
    bus.result_bins = 'x;
  endtask

  task automatic pair(input logic [31:0] lo, input logic [31:0] hi);
    store_word(1'b0, lo);
    store_word(1'b1, hi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_last;
    rst             = 1'b1;
    bus.store       = 1'b0;
    bus.half_sel    = 1'b0;
    bus.result_bins = 'x;
    bus.layer_start = 1'b0;
    bus.cfg_words   = '0;
    bus.out_ready   = 1'b1;
    tick();
    check_en = 1'b1;
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_data",  bus.out_data, 64'h0);
    chk("rst_stall", 64'(bus.stall), 64'h0);
    rst = 1'b0;

    // 1: basic pair, head visible one edge after hi, gone after one cycle
    store_word(1'b0, 32'h0000_00FF);
    chk("t1_nolo_valid", 64'(bus.out_valid), 64'h0);
    store_word(1'b1, 32'hA5A5_0000);
    chk("t1_valid", 64'(bus.out_valid), 64'h1);
    chk("t1_data",  bus.out_data, 64'hA5A5_0000_0000_00FF);
    tick();
    chk("t1_popped", 64'(bus.out_valid), 64'h0);

    // 2: layer of 3 words, 4th starts next layer
    bus.layer_start = 1'b1;
    bus.cfg_words   = 16'd3;
    tick();
    bus.layer_start = 1'b0;
    exp_last = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      pair(32'h0000_0010 + 32'(k), 32'h0000_0020 + 32'(k));
      chk("t2_last", 64'(bus.out_last), 64'(exp_last[k]));
    end
    tick();

    // 3: fill with out_ready low, overflow, drain in order
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pair(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k));
      chk("t3_stall", 64'(bus.stall), 64'(k + 1 >= 7));
    end
    pair(32'h1000_0008, 32'h2000_0008);
    chk("t3_ovf",   64'(bus.err_ovf), 64'h1);
    chk("t3_count", 64'(mq.size()), 64'd8);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain", bus.out_data, {32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)});
      tick();
    end
    chk("t3_empty", 64'(bus.out_valid), 64'h0);

    // 4: full FIFO, hi with simultaneous pop is accepted
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) pair(32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k));
    store_word(1'b0, 32'h3000_0008);
    bus.out_ready = 1'b1;
    store_word(1'b1, 32'h4000_0008);
    bus.out_ready = 1'b0;
    chk("t4_ovf",   64'(bus.err_ovf), 64'h0);
    chk("t4_stall", 64'(bus.stall), 64'h1);
    chk("t4_count", 64'(mq.size()), 64'd8);
    chk("t4_head",  bus.out_data, 64'h4000_0001_3000_0001);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("t4_tail",  bus.out_data, 64'h4000_0008_3000_0008);
    tick();
    chk("t4_empty", 64'(bus.out_valid), 64'h0);

    // 5: ordering errors
    do_reset();
    store_word(1'b1, 32'hBAD0_0000);
    chk("t5_seq_hi",   64'(bus.err_seq), 64'h1);
    chk("t5_nopush",   64'(bus.out_valid), 64'h0);
    store_word(1'b0, 32'h1111_1111);
    store_word(1'b0, 32'h2222_2222);
    store_word(1'b1, 32'h3333_3333);
    chk("t5_seq",  64'(bus.err_seq), 64'h1);
    chk("t5_data", bus.out_data, 64'h3333_3333_2222_2222);
    tick();

    // 6: reset mid-operation
    do_reset();
    bus.out_ready = 1'b0;
    store_word(1'b1, 32'h0BAD_0BAD);
    for (int k = 0; k < 3; k++) pair(32'h5000_0000 + 32'(k), 32'h6000_0000 + 32'(k));
    store_word(1'b0, 32'h7777_7777);
    chk("t6_pre_seq", 64'(bus.err_seq), 64'h1);
    do_reset();
    chk("t6_valid", 64'(bus.out_valid), 64'h0);
    chk("t6_stall", 64'(bus.stall), 64'h0);
    chk("t6_seq",   64'(bus.err_seq), 64'h0);
    chk("t6_ovf",   64'(bus.err_ovf), 64'h0);
    pair(32'hCAFE_0001, 32'hBEEF_0002);
    chk("t6_data",  bus.out_data, 64'hBEEF_0002_CAFE_0001);
    chk("t6_seq2",  64'(bus.err_seq), 64'h0);
    bus.out_ready = 1'b1;
    tick();
    tick();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
